axi_mem_slv: RTL and testbench

Parametrised AXI4 memory-mapped slave with an internal word array, used as the synthesizable endpoint behind the master/passthrough AXI chain in the `chip` block design. It replaces the fixed-width VIP slave memory model with RTL that supports configurable data, address, ID width and depth. It handles INCR, FIXED and WRAP bursts, byte strobes, independent read and write channels, and optional error responses.

---
 rtl/axi_mem_slv_pkg.sv | 38 +++
 rtl/axi_mem_slv_addr_gen.sv | 48 ++++
 rtl/axi_mem_slv.sv | 268 ++++++++++++++++++++++++++
 tb/tb_axi_mem_slv.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_slv_pkg.sv
// Shared types and helpers for the axi_mem_slv AXI4 memory slave.
package axi_mem_slv_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Number of byte-address bits covered by one data word.
    function automatic int clog2_bytes(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_mem_slv_addr_gen.sv
// Next-beat address for one AXI burst; used by both the write and read paths.
// The result is always word aligned, which also aligns an unaligned start.
module axi_mem_slv_addr_gen
    import axi_mem_slv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    localparam int SHIFT  = clog2_bytes(DATA_W);
    localparam int WORD_W = ADDR_W - SHIFT;

    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] word_inc;
    logic [WORD_W-1:0] wrap_mask;
    logic [WORD_W-1:0] next_word;

    // Byte-lane bits of the current address never influence the next beat.
    logic unused_low;
    assign unused_low = &{1'b0, addr[SHIFT-1:0]};

    // Select the next word by burst type; illegal WRAP lengths and the
    // reserved encoding fall through to INCR.
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default before the case so no latch is inferred.
    always_comb begin
        word      = addr[ADDR_W-1:SHIFT];
        word_inc  = word + WORD_W'(1);
        wrap_mask = WORD_W'(len);
        next_word = word_inc;
        case (burst)
            BURST_FIXED: next_word = word;
            BURST_WRAP: begin
                if (wrap_len_ok(len)) begin
                    next_word = (word & ~wrap_mask) | (word_inc & wrap_mask);
                end
            end
            default: next_word = word_inc;
        endcase
        next_addr = {next_word, {SHIFT{1'b0}}};
    end

endmodule

// File: rtl/axi_mem_slv.sv
// AXI4 memory-mapped slave backed by a true dual-port word array.
// Independent write (AW/W/B) and read (AR/R) FSMs, one transaction each.
// Optional build macro: AXI_MEM_SLV_ERR_EN enables SLVERR responses for
// out-of-range beats, illegal WRAP lengths, narrow sizes and early wlast.
module axi_mem_slv
    import axi_mem_slv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int SHIFT  = clog2_bytes(DATA_W);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Word index of a byte address, taken modulo DEPTH.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[SHIFT +: IDX_W];
    endfunction

`ifdef AXI_MEM_SLV_ERR_EN
    localparam int         WORD_W    = ADDR_W - SHIFT;
    localparam logic [2:0] FULL_SIZE = 3'(SHIFT);

    // True when the un-wrapped word index falls outside the array.
    function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:SHIFT] >= WORD_W'(DEPTH);
    endfunction
`endif

    w_state_e          w_state;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_next;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic [1:0]        w_burst;
    logic [ID_W-1:0]   w_id;
    logic              w_beat_ok;

    r_state_e          r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_next;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [1:0]        r_burst;

    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic ar_fire;
    logic r_fire;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign b_fire  = bvalid && bready;
    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;

`ifdef AXI_MEM_SLV_ERR_EN
    logic w_err;
    logic r_err;
    logic w_beat_err;

    assign w_beat_ok  = !addr_oob(w_addr);
    assign w_beat_err = addr_oob(w_addr) || (wlast && (w_cnt != w_len));
`else
    assign w_beat_ok = 1'b1;

    // Size and wlast carry no meaning when every response is OKAY.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, awsize, arsize, wlast};
`endif

    axi_mem_slv_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_addr_gen (
        .addr      (w_addr),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_next)
    );

    axi_mem_slv_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_addr_gen (
        .addr      (r_addr),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_next)
    );

    // Write port: byte-enabled store of each accepted W beat.
    // NOTE: the array is deliberately left out of reset so it maps onto RAM;
    // only the write enable is qualified by reset.
    always_ff @(posedge clock) begin
        if (w_fire && !reset && w_beat_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Write FSM: AW capture, beat counting, then hold B until accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_id    <= '0;
`ifdef AXI_MEM_SLV_ERR_EN
            w_err   <= 1'b0;
`endif
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_burst <= awburst;
                        w_id    <= awid;
                        w_cnt   <= '0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
`ifdef AXI_MEM_SLV_ERR_EN
                        w_err   <= (awsize != FULL_SIZE) ||
                                   ((awburst == BURST_WRAP) && !wrap_len_ok(awlen));
`endif
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= w_next;
                        w_cnt  <= w_cnt + 8'd1;
`ifdef AXI_MEM_SLV_ERR_EN
                        w_err  <= w_err || w_beat_err;
`endif
                        // The beat count, not wlast, closes the burst.
                        if (w_cnt == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
`ifdef AXI_MEM_SLV_ERR_EN
                            bresp   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
`else
                            bresp   <= RESP_OKAY;
`endif
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_fire) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: registered R beats; the array is read on the same edge that
    // accepts AR or an R beat, so a concurrent write is seen as old data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
`ifdef AXI_MEM_SLV_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_burst <= arburst;
                        r_cnt   <= '0;
                        rid     <= arid;
                        rdata   <= mem[word_idx(araddr)];
                        rlast   <= (arlen == 8'd0);
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
`ifdef AXI_MEM_SLV_ERR_EN
                        r_err   <= (arsize != FULL_SIZE) ||
                                   ((arburst == BURST_WRAP) && !wrap_len_ok(arlen));
                        rresp   <= ((arsize != FULL_SIZE) ||
                                    ((arburst == BURST_WRAP) && !wrap_len_ok(arlen)) ||
                                    addr_oob(araddr)) ? RESP_SLVERR : RESP_OKAY;
`endif
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            r_cnt  <= r_cnt + 8'd1;
                            rdata  <= mem[word_idx(r_next)];
                            rlast  <= ((r_cnt + 8'd1) == r_len);
`ifdef AXI_MEM_SLV_ERR_EN
                            rresp  <= (r_err || addr_oob(r_next)) ? RESP_SLVERR : RESP_OKAY;
`endif
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slv.sv
// Directed self-checking bench for axi_mem_slv (DATA_W=32, DEPTH=1024).
module tb_axi_mem_slv;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 1024;
    localparam int WAIT_MAX = 20;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                clock = 1'b0;
    logic                reset;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] rexp [16];

    axi_mem_slv #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic aw_req(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] len, input logic [1:0] burst, input string tag);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < WAIT_MAX) begin step(); n++; end
        check({tag, "_awready"}, awready, 1);
        step();
        awvalid = 1'b0;
        check({tag, "_wready_lat"}, wready, 1);
    endtask

    task automatic w_beat(input logic [DATA_W-1:0] d, input logic [3:0] s, input logic last,
                          input string tag);
        int n;
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        n = 0;
        while (!wready && n < WAIT_MAX) begin step(); n++; end
        check({tag, "_wready"}, wready, 1);
        step();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_take(input logic [ID_W-1:0] id, input logic [1:0] resp, input string tag);
        int n;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < WAIT_MAX) begin step(); n++; end
        check({tag, "_bvalid"}, bvalid, 1);
        check({tag, "_bid"}, bid, id);
        check({tag, "_bresp"}, bresp, resp);
        step();
        bready = 1'b0;
        check({tag, "_bvalid_drop"}, bvalid, 0);
        check({tag, "_awready_back"}, awready, 1);
    endtask

    task automatic ar_req(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input logic [7:0] len, input logic [1:0] burst, input string tag);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < WAIT_MAX) begin step(); n++; end
        check({tag, "_arready"}, arready, 1);
        step();
        arvalid = 1'b0;
        check({tag, "_rvalid_lat"}, rvalid, 1);
    endtask

    // Consume len+1 beats with rready held high: every cycle must carry a beat.
    task automatic r_beats(input logic [ID_W-1:0] id, input logic [7:0] len, input string tag);
        rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            check($sformatf("%s_rvalid%0d", tag, b), rvalid, 1);
            check($sformatf("%s_rdata%0d", tag, b), rdata, rexp[b]);
            check($sformatf("%s_rid%0d", tag, b), rid, id);
            check($sformatf("%s_rresp%0d", tag, b), rresp, OKAY);
            check($sformatf("%s_rlast%0d", tag, b), rlast, (b == int'(len)));
            step();
        end
        rready = 1'b0;
        check({tag, "_rvalid_end"}, rvalid, 0);
        check({tag, "_arready_end"}, arready, 1);
    endtask

    task automatic write1(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d,
                          input string tag);
        aw_req(4'h0, addr, 8'd0, INCR, tag);
        w_beat(d, 4'hF, 1'b1, tag);
        b_take(4'h0, OKAY, tag);
    endtask

    initial begin
        reset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_b", {bid, bresp}, 0);
        check("rst_r", {rid, rdata, rresp, rlast}, 0);
        reset = 1'b0;
        step();

        // Single write then single read at 0x10
        aw_req(4'h3, 32'h10, 8'd0, INCR, "single_w");
        w_beat(32'hDEADBEEF, 4'hF, 1'b1, "single_w");
        check("single_bvalid_lat", bvalid, 1);
        check("single_wready_off", wready, 0);
        b_take(4'h3, OKAY, "single_w");
        ar_req(4'h3, 32'h10, 8'd0, INCR, "single_r");
        rexp[0] = 32'hDEADBEEF;
        r_beats(4'h3, 8'd0, "single_r");

        // INCR 4 beats at 0x100, beat 2 writes only the low half
        write1(32'h104, 32'h12345678, "prefill");
        aw_req(4'h5, 32'h100, 8'd3, INCR, "incr_w");
        w_beat(32'hA0A0A0A0, 4'hF, 1'b0, "incr_w0");
        w_beat(32'hB1B2B3B4, 4'h3, 1'b0, "incr_w1");
        w_beat(32'hC0C0C0C0, 4'hF, 1'b0, "incr_w2");
        w_beat(32'hD0D0D0D0, 4'hF, 1'b1, "incr_w3");
        b_take(4'h5, OKAY, "incr_w");
        rexp[0] = 32'hA0A0A0A0; rexp[1] = 32'h1234B3B4;
        rexp[2] = 32'hC0C0C0C0; rexp[3] = 32'hD0D0D0D0;
        ar_req(4'h5, 32'h100, 8'd3, INCR, "incr_r");
        r_beats(4'h5, 8'd3, "incr_r");

        // WRAP 4 beats at 0x108: 0x108, 0x10C, 0x100, 0x104
        rexp[0] = 32'hC0C0C0C0; rexp[1] = 32'hD0D0D0D0;
        rexp[2] = 32'hA0A0A0A0; rexp[3] = 32'h1234B3B4;
        ar_req(4'h6, 32'h108, 8'd3, WRAP, "wrap_r");
        r_beats(4'h6, 8'd3, "wrap_r");

        // FIXED 3 beats to 0x20: last value wins, neighbour untouched
        write1(32'h24, 32'h55555555, "fix_nb");
        aw_req(4'h7, 32'h20, 8'd2, FIXED, "fix_w");
        w_beat(32'h00000011, 4'hF, 1'b0, "fix_w0");
        w_beat(32'h00000022, 4'hF, 1'b0, "fix_w1");
        w_beat(32'h00000033, 4'hF, 1'b1, "fix_w2");
        b_take(4'h7, OKAY, "fix_w");
        rexp[0] = 32'h33; rexp[1] = 32'h33;
        ar_req(4'h7, 32'h20, 8'd1, FIXED, "fix_r");
        r_beats(4'h7, 8'd1, "fix_r");
        rexp[0] = 32'h55555555;
        ar_req(4'h7, 32'h24, 8'd0, INCR, "fix_nb_r");
        r_beats(4'h7, 8'd0, "fix_nb_r");

        // Read with rready 1-0-1: stable during the stall, no bubbles otherwise
        ar_req(4'h4, 32'h100, 8'd3, INCR, "stall");
        rready = 1'b1;
        check("stall_b0", rdata, 32'hA0A0A0A0);
        step();
        check("stall_b1", rdata, 32'h1234B3B4);
        rready = 1'b0;
        step();
        check("stall_hold_valid", rvalid, 1);
        check("stall_hold_data", rdata, 32'h1234B3B4);
        check("stall_hold_last", rlast, 0);
        rready = 1'b1;
        step();
        check("stall_b2", {rvalid, rdata}, {1'b1, 32'hC0C0C0C0});
        step();
        check("stall_b3", {rvalid, rlast, rdata}, {2'b11, 32'hD0D0D0D0});
        step();
        rready = 1'b0;
        check("stall_done", rvalid, 0);

        // Same-edge write and read of 0x10: read returns the old word
        aw_req(4'h1, 32'h10, 8'd0, INCR, "rbw_w");
        wdata = 32'h0BADF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        arid = 4'h2; araddr = 32'h10; arlen = 8'd0; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
        check("rbw_both_ready", {wready, arready}, 2'b11);
        step();
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        check("rbw_rvalid", rvalid, 1);
        check("rbw_old_data", rdata, 32'hDEADBEEF);
        rready = 1'b1;
        step();
        rready = 1'b0;
        b_take(4'h1, OKAY, "rbw_w");
        rexp[0] = 32'h0BADF00D;
        ar_req(4'h2, 32'h10, 8'd0, INCR, "rbw_new");
        r_beats(4'h2, 8'd0, "rbw_new");

        // Read issued the cycle after the write beat sees the new data
        aw_req(4'h1, 32'h14, 8'd0, INCR, "vis_w");
        w_beat(32'hCAFEF00D, 4'hF, 1'b1, "vis_w");
        ar_req(4'h3, 32'h14, 8'd0, INCR, "vis_r");
        rexp[0] = 32'hCAFEF00D;
        r_beats(4'h3, 8'd0, "vis_r");
        b_take(4'h1, OKAY, "vis_w");

        // Reset in the middle of an 8-beat write
        aw_req(4'h9, 32'h200, 8'd7, INCR, "rst_mid");
        w_beat(32'h1, 4'hF, 1'b0, "rst_mid0");
        w_beat(32'h2, 4'hF, 1'b0, "rst_mid1");
        w_beat(32'h3, 4'hF, 1'b0, "rst_mid2");
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_awready", awready, 1);
        check("rst_mid_bvalid", bvalid, 0);
        check("rst_mid_wready", wready, 0);
        repeat (3) step();
        check("rst_mid_no_b", bvalid, 0);

        // Write to word DEPTH+1: aliases to word 1 unless errors are enabled
        write1(32'h4, 32'h11111111, "alias_pre");
        aw_req(4'h2, ADDR_W'((DEPTH + 1) * (DATA_W / 8)), 8'd0, INCR, "alias_w");
        w_beat(32'h22222222, 4'hF, 1'b1, "alias_w");
`ifdef AXI_MEM_SLV_ERR_EN
        b_take(4'h2, SLVERR, "alias_w");
        rexp[0] = 32'h11111111;
`else
        b_take(4'h2, OKAY, "alias_w");
        rexp[0] = 32'h22222222;
`endif
        ar_req(4'h2, 32'h4, 8'd0, INCR, "alias_r");
        r_beats(4'h2, 8'd0, "alias_r");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
